tpu_rename_grp: RTL
===================

// Module: tpu_rename_grp
// PURPOSE
// Multi-lane successor of the single-line TPU rename stage. Each cycle it renames up to LANES
// issue-queue lines against an internally held logical->physical map table. It applies intra-group
// dependencies, tracks physical-register readiness from writeback broadcasts, and supports whole-map
// reload for branch recovery. It sits between the issue queue and the TPU dispatch pipeline.
// PARAMETERS
// LANES            2   lines renamed per cycle (lane 0 oldest)
// LOG_REGS         16  logical registers; LOG_BITS = $clog2(LOG_REGS)
// PHYS_BITS        6   physical register index width; map entry = {rdy, preg} = PHYS_BITS+1 bits
// ISQ_IDX_BITS_NUM 2   issue-queue index width carried through
// PORTS
// clk          in   1                          clock, all state on posedge
// rst          in   1                          synchronous reset, active-high
// in_vld       in   LANES                      per-lane line valid
// in_rdy       out  1                          group accepted this cycle when |in_vld & in_rdy
// in_idx       in   LANES*ISQ_IDX_BITS_NUM     issue-queue index per lane
// in_src1_vld  in   LANES                      src1 used
// in_lsrc1     in   LANES*LOG_BITS             logical src1
// in_src2_vld  in   LANES                      src2 used
// in_lsrc2     in   LANES*LOG_BITS             logical src2
// in_ldst_vld  in   LANES                      instruction writes a destination
// in_ldst      in   LANES*LOG_BITS             logical destination
// in_pdst      in   LANES*PHYS_BITS            pre-allocated physical destination
// wb_vld       in   1                          writeback broadcast valid
// wb_preg      in   PHYS_BITS                  physical reg becoming ready
// ld_map_vld   in   1                          reload whole map (recovery)
// ld_map       in   LOG_REGS*(PHYS_BITS+1)     map image, entry i at [(i+1)*(PHYS_BITS+1)-1 -: PHYS_BITS+1]
// out_vld      out  LANES                      per-lane renamed output valid
// out_rdy      in   1                          downstream accepts output register
// out_idx      out  LANES*ISQ_IDX_BITS_NUM     passed-through index
// out_psrc1    out  LANES*(PHYS_BITS+1)        {rdy, preg}; all-zero when src1 unused
// out_psrc2    out  LANES*(PHYS_BITS+1)        {rdy, preg}; all-zero when src2 unused
// out_pdst     out  LANES*(PHYS_BITS+1)        {ldst_vld, pdst}
// cur_map      out  LOG_REGS*(PHYS_BITS+1)     current map table, same packing as ld_map
// BEHAVIOUR
// - Reset: map entry i = {1'b1, i[PHYS_BITS-1:0]} (identity, ready). out_vld, out_idx, out_psrc*,
//   and out_pdst are 0.
// - Output register is one stage: latency 1 cycle from accept to out_vld.
// - in_rdy = ~ld_map_vld & (~|out_vld | out_rdy). With out_vld!=0 & ~out_rdy, outputs hold stable.
// - On accept: out_vld <= in_vld. Lanes with in_vld=0 do not touch the map.
// - Source lookup, lane k: a younger-lane bypass applies when a lane j<k has in_vld & in_ldst_vld and
//   ldst == lsrc. The highest such j supplies {1'b0, pdst_j}. Otherwise the map entry is used,
//   with rdy forced to 1 if wb_vld & wb_preg == entry.preg in the same cycle.
// - Map update on accept: map[ldst] <= {1'b0, pdst} for each valid writing lane. If several lanes write
//   the same ldst, the highest lane wins.
// - Wakeup: each cycle with wb_vld, every map entry whose preg == wb_preg sets rdy=1. Same for held
//   out_psrc1/2 fields of valid output lanes, so waiting outputs see wakeup.
// - Priority per map entry: ld_map_vld > rename write > wakeup. A rename and a wakeup to the same
//   entry in one cycle leave rdy=0.
// - ld_map_vld: the map is loaded from ld_map next cycle and no group is accepted that cycle.
//   The output register is also flushed: out_vld <= 0.
// - rst asserted mid-operation overrides all the above on that edge; in-flight outputs are discarded.
// - cur_map is the registered table (pre-update view of the current cycle).
// TESTING
// - Reset, then idle: cur_map entry i == {1,i}; out_vld==0; in_rdy==1.
// - Lane0 {src1=r4,src2=r7,ldst=r2,pdst=32}: out_psrc1=={1,4}, out_psrc2=={1,7},
//   out_pdst=={1,32}, then map[2]=={0,32}.
// - Group: lane0 ldst=r3 pdst=40; lane1 src1=r3, ldst=r3 pdst=41. Expect lane1 psrc1=={0,40} and map[3]=={0,41}.
// - After map[5]={0,33}: wb_vld preg=33 -> map[5]=={1,33}. Same cycle, lane0 src1=r5 gives psrc1=={1,33}.
// - Hold output with out_rdy=0 and pulse wb preg=40: held lane1 psrc1 becomes {1,40}, and in_rdy==0 while held.
// - ld_map_vld with identity image while renaming lane0 ldst=r2: group not accepted, map==identity,
//   out_vld==0. Also hit rst mid-stream: all outputs and map return to reset values.

Source files
------------

// File: rtl/tpu_rename_grp.sv
// tpu_rename_grp: multi-lane register rename stage.
// Renames up to LANES issue-queue lines per cycle against a logical->physical map table.
// It applies intra-group bypass, tracks readiness from writeback broadcasts and supports
// whole-map reload for branch recovery. Lane 0 is the oldest lane.
module tpu_rename_grp #(
   parameter int LANES            = 2,
   parameter int LOG_REGS         = 16,
   parameter int PHYS_BITS        = 6,
   parameter int ISQ_IDX_BITS_NUM = 2,
   localparam int LOG_BITS        = $clog2(LOG_REGS),
   localparam int ENT_BITS        = PHYS_BITS + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LANES-1:0]                in_vld,
   output logic                            in_rdy,
   input  logic [LANES*ISQ_IDX_BITS_NUM-1:0] in_idx,
   input  logic [LANES-1:0]                in_src1_vld,
   input  logic [LANES*LOG_BITS-1:0]       in_lsrc1,
   input  logic [LANES-1:0]                in_src2_vld,
   input  logic [LANES*LOG_BITS-1:0]       in_lsrc2,
   input  logic [LANES-1:0]                in_ldst_vld,
   input  logic [LANES*LOG_BITS-1:0]       in_ldst,
   input  logic [LANES*PHYS_BITS-1:0]      in_pdst,
   input  logic                            wb_vld,
   input  logic [PHYS_BITS-1:0]            wb_preg,
   input  logic                            ld_map_vld,
   input  logic [LOG_REGS*ENT_BITS-1:0]    ld_map,
   output logic [LANES-1:0]                out_vld,
   input  logic                            out_rdy,
   output logic [LANES*ISQ_IDX_BITS_NUM-1:0] out_idx,
   output logic [LANES*ENT_BITS-1:0]       out_psrc1,
   output logic [LANES*ENT_BITS-1:0]       out_psrc2,
   output logic [LANES*ENT_BITS-1:0]       out_pdst,
   output logic [LOG_REGS*ENT_BITS-1:0]    cur_map
);

   // map entry / output source field: {rdy, preg}
   typedef logic [ENT_BITS-1:0] ent_t;

   ent_t                          map_q    [LOG_REGS];
   logic [LOG_BITS-1:0]           lsrc     [LANES][2];
   logic                          src_use  [LANES][2];
   logic [LOG_BITS-1:0]           ldst     [LANES];
   logic [PHYS_BITS-1:0]          pdst     [LANES];
   ent_t                          src_ent  [LANES][2];
   ent_t                          tmp_ent;
   ent_t                          psrc_q   [LANES][2];
   logic                          used_q   [LANES][2];
   ent_t                          pdst_q   [LANES];
   logic [ISQ_IDX_BITS_NUM-1:0]   idx_q    [LANES];
   logic                          accept;

   assign in_rdy = ~ld_map_vld & (~|out_vld | out_rdy);
   assign accept = |in_vld & in_rdy;

   // unpack the flat per-lane input buses
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lsrc[k][0]    = in_lsrc1[k*LOG_BITS +: LOG_BITS];
         lsrc[k][1]    = in_lsrc2[k*LOG_BITS +: LOG_BITS];
         src_use[k][0] = in_src1_vld[k];
         src_use[k][1] = in_src2_vld[k];
         ldst[k]       = in_ldst[k*LOG_BITS +: LOG_BITS];
         pdst[k]       = in_pdst[k*PHYS_BITS +: PHYS_BITS];
      end
   end

   // source lookup: map entry with same-cycle wakeup, overridden by the closest older writing lane
   always_comb begin
      // NOTE: every variable written here gets a value before any condition so no latch is inferred.
      tmp_ent = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int s = 0; s < 2; s++) begin
            tmp_ent = map_q[lsrc[k][s]];
            if (wb_vld && tmp_ent[PHYS_BITS-1:0] == wb_preg) tmp_ent[PHYS_BITS] = 1'b1;
            // ascending scan: the highest older lane is applied last and wins
            for (int j = 0; j < LANES; j++) begin
               if (j < k && in_vld[j] && in_ldst_vld[j] && ldst[j] == lsrc[k][s])
                  tmp_ent = {1'b0, pdst[j]};
            end
            src_ent[k][s] = src_use[k][s] ? tmp_ent : '0;
         end
      end
   end

   // map table: reload > rename write > wakeup
   always_ff @(posedge clk) begin
      // NOTE: the map is a small flop array, not RAM; it must reset to identity so it is reset entry by entry.
      if (rst) begin
         for (int i = 0; i < LOG_REGS; i++) map_q[i] <= {1'b1, PHYS_BITS'(i)};
      end else if (ld_map_vld) begin
         for (int i = 0; i < LOG_REGS; i++) map_q[i] <= ld_map[i*ENT_BITS +: ENT_BITS];
      end else begin
         // NOTE: non-blocking assignments; a later assignment to the same entry overrides an earlier one.
         for (int i = 0; i < LOG_REGS; i++) begin
            if (wb_vld && map_q[i][PHYS_BITS-1:0] == wb_preg) map_q[i][PHYS_BITS] <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
               if (accept && in_vld[k] && in_ldst_vld[k] && ldst[k] == LOG_BITS'(i))
                  map_q[i] <= {1'b0, pdst[k]};
            end
         end
      end
   end

   // output register: flush on reload, load on accept, otherwise hold and absorb wakeups
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld <= '0;
         for (int k = 0; k < LANES; k++) begin
            idx_q[k]  <= '0;
            pdst_q[k] <= '0;
            for (int s = 0; s < 2; s++) begin
               psrc_q[k][s] <= '0;
               used_q[k][s] <= 1'b0;
            end
         end
      end else if (ld_map_vld) begin
         out_vld <= '0;
      end else if (in_rdy) begin
         out_vld <= in_vld;
         if (|in_vld) begin
            for (int k = 0; k < LANES; k++) begin
               idx_q[k]  <= in_idx[k*ISQ_IDX_BITS_NUM +: ISQ_IDX_BITS_NUM];
               pdst_q[k] <= {in_ldst_vld[k], pdst[k]};
               for (int s = 0; s < 2; s++) begin
                  psrc_q[k][s] <= src_ent[k][s];
                  used_q[k][s] <= src_use[k][s];
               end
            end
         end
      end else begin
         // unused sources stay all-zero even when wb_preg is 0
         for (int k = 0; k < LANES; k++) begin
            for (int s = 0; s < 2; s++) begin
               if (out_vld[k] && used_q[k][s] && wb_vld && psrc_q[k][s][PHYS_BITS-1:0] == wb_preg)
                  psrc_q[k][s][PHYS_BITS] <= 1'b1;
            end
         end
      end
   end

   // pack registered state onto the flat output buses
   always_comb begin
      out_idx   = '0;
      out_psrc1 = '0;
      out_psrc2 = '0;
      out_pdst  = '0;
      cur_map   = '0;
      for (int k = 0; k < LANES; k++) begin
         out_idx[k*ISQ_IDX_BITS_NUM +: ISQ_IDX_BITS_NUM] = idx_q[k];
         out_psrc1[k*ENT_BITS +: ENT_BITS]             = psrc_q[k][0];
         out_psrc2[k*ENT_BITS +: ENT_BITS]             = psrc_q[k][1];
         out_pdst[k*ENT_BITS +: ENT_BITS]              = pdst_q[k];
      end
      for (int i = 0; i < LOG_REGS; i++) cur_map[i*ENT_BITS +: ENT_BITS] = map_q[i];
   end

endmodule
